axil_native_master: RTL

AXI4-Lite initiator bridging a simple single-outstanding command/response port (CPU or testbench side)

---
 rtl/axil_native_master.sv | 130 +++++++++++++
 1 files changed

// File: rtl/axil_native_master.sv
// axil_native_master: single-outstanding command/response port driving an AXI4-Lite slave
// Optional completion counters behind AXIL_MASTER_STATS_EN
module axil_native_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
`ifdef AXIL_MASTER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_wr_count,
  output logic [STAT_WIDTH-1:0] stat_rd_count,
  output logic [STAT_WIDTH-1:0] stat_err_count
`endif
);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA} state_t;
  state_t state;
  logic aw_ok, w_ok;
  // a channel counts as done once its valid has dropped or is handshaking now
  assign aw_ok = !m_axil_awvalid || m_axil_awready;
  assign w_ok = !m_axil_wvalid || m_axil_wready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid <= 1'b0;
      m_axil_bready <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          m_axil_awaddr <= cmd_addr;
          m_axil_araddr <= cmd_addr;
          m_axil_wdata <= cmd_wdata;
          m_axil_wstrb <= cmd_wstrb;
          if (|cmd_wstrb) begin
            state <= WR;
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid <= 1'b1;
          end else begin
            state <= RADDR;
            m_axil_arvalid <= 1'b1;
          end
        end
        WR: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready) m_axil_wvalid <= 1'b0;
          if (aw_ok && w_ok) begin
            state <= WRESP;
            m_axil_bready <= 1'b1;
          end
        end
        WRESP: if (m_axil_bvalid) begin
          m_axil_bready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err <= |m_axil_bresp;
          rsp_rdata <= '0;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
        RADDR: if (m_axil_arready) begin
          m_axil_arvalid <= 1'b0;
          m_axil_rready <= 1'b1;
          state <= RDATA;
        end
        RDATA: if (m_axil_rvalid) begin
          m_axil_rready <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err <= |m_axil_rresp;
          rsp_rdata <= m_axil_rdata;
          cmd_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXIL_MASTER_STATS_EN
  logic fin_wr, fin_rd, fin_err;
  assign fin_wr = state == WRESP && m_axil_bvalid;
  assign fin_rd = state == RDATA && m_axil_rvalid;
  assign fin_err = (fin_wr && |m_axil_bresp) || (fin_rd && |m_axil_rresp);
  // counters update on the same edge that raises rsp_valid and stick at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_count <= '0;
      stat_rd_count <= '0;
      stat_err_count <= '0;
    end else begin
      if (fin_wr && !(&stat_wr_count)) stat_wr_count <= stat_wr_count + 1'b1;
      if (fin_rd && !(&stat_rd_count)) stat_rd_count <= stat_rd_count + 1'b1;
      if (fin_err && !(&stat_err_count)) stat_err_count <= stat_err_count + 1'b1;
    end
  end
`endif
endmodule
